instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  PC register, next-PC selection and instruction-fetch sequencer for the cpu31 core.
//  Fetches from instruction memory over a req/ack handshake and holds the word in IR.
//  Drives op/func into the control unit and applies the pcsource it returns to choose the next PC.
//  Sits directly upstream of the control decoder; jal link value (pc_plus4) goes to the regfile write mux.
// PARAMETERS
//  RESET_PC  32'h0040_0000  PC loaded on reset
// PORTS
//  clk          in   1   system clock, rising edge
//  rst_n        in   1   asynchronous reset, active low
//  imem_req     out  1   fetch request; addr held stable while high
//  imem_addr    out  32  fetch address (= pc)
//  imem_ack     in   1   fetch data valid this cycle
//  imem_rdata   in   32  fetched instruction word
//  pcsource     in   2   next-PC select from control: 00 pc+4, 01 branch, 10 jr, 11 j/jal
//  rs_data      in   32  register rs value (jr target)
//  stall        in   1   hold current instruction in EXEC (multi-cycle data memory)
//  instr        out  32  IR contents
//  op           out  6   instr[31:26]
//  func         out  6   instr[5:0]
//  instr_valid  out  1   high in EXEC: IR valid, control outputs meaningful
//  pc           out  32  PC of instruction in IR
//  pc_plus4     out  32  pc + 4 (jal link)
//  retire_cnt   out  32  count of completed instructions
//  fault        out  1   sticky: misaligned next-PC detected, core halted
// BEHAVIOUR
//  Reset (rst_n low, async): state=IDLE, pc=RESET_PC, IR=0, retire_cnt=0, fault=0, imem_req=0,
//   instr_valid=0. Reset mid-fetch aborts the request immediately; a late ack is ignored.
//  FSM: IDLE -> FETCH (unconditional, one cycle after reset release).
//   FETCH: imem_req=1, imem_addr=pc. On imem_ack: IR<=imem_rdata, -> EXEC. Else stay.
//   EXEC: instr_valid=1. If stall: stay, pc/IR unchanged. Else compute next_pc,
//    retire_cnt<=retire_cnt+1; if next_pc[1:0]!=0 -> HALT (fault<=1, pc unchanged), else pc<=next_pc, -> FETCH.
//   HALT: terminal until reset; imem_req=0, instr_valid=0, fault=1.
//  imem_req, instr_valid are Moore outputs decoded from state; ack outside FETCH is ignored.
//  Zero-wait memory (ack in first FETCH cycle) gives 2 cycles/instruction minimum.
//  next_pc (all mod 2^32, wrap without flag):
//   00: pc+4;  01: pc+4 + (sext(IR[15:0]) << 2);  10: rs_data;  11: {pc_plus4[31:28], IR[25:0], 2'b00}.
//  pcsource sampled only on the EXEC cycle where stall=0; values while stalled are don't-care.
//  Stall and pcsource change in same cycle: stall wins; pcsource re-sampled at release.
//  retire_cnt wraps FFFF_FFFF -> 0. Faulting instruction counts as retired.
//  op/func/pc/pc_plus4 combinational from IR/pc, stable whole EXEC.
// TESTING
//  Reset release, ack after 3 cycles, rdata=32'h2008_0005 -> imem_addr=0040_0000, op=6'h08, instr_valid 1 cycle, pc->0040_0004.
//  pc=0040_0010, IR imm=16'hFFFE, pcsource=01 -> pc=0040_000C; imm=16'h0003 -> pc=0040_0020.
//  pcsource=11, IR[25:0]=26'h010_0008 at pc=0040_0000 -> pc=0040_0020; pcsource=10, rs_data=0040_0100 -> pc=0040_0100.
//  pcsource=10, rs_data=0040_0102 -> fault=1, state HALT, imem_req stays 0, pc unchanged, retire_cnt+1.
//  stall held 4 cycles in EXEC with pcsource toggling -> pc/IR constant, instr_valid high 5 cycles, one retire.
//  rst_n low while imem_req high, ack arrives during reset -> IR stays 0; after release fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// PC register, next-PC select and fetch sequencer: IDLE -> FETCH -> EXEC, 2 cycles/instr minimum.
// Backpressure: FETCH waits for imem_ack; EXEC holds pc/IR while stall is high; misaligned next-PC halts.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic [1:0]  pcsource,
  input  logic [31:0] rs_data,
  input  logic        stall,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [5:0]  func,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] retire_cnt,
  output logic        fault
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_q;
  logic [31:0] ir_q;
  logic [31:0] retire_q;
  logic        fault_q;
  logic [31:0] next_pc;
  logic [31:0] br_offset;
  logic        retire;
  logic        misaligned;

  assign pc_plus4  = pc_q + 32'd4;
  assign br_offset = {{14{ir_q[15]}}, ir_q[15:0], 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    case (pcsource)
      2'b00: next_pc = pc_plus4;
      2'b01: next_pc = pc_plus4 + br_offset;
      2'b10: next_pc = rs_data;
      2'b11: next_pc = {pc_plus4[31:28], ir_q[25:0], 2'b00};
      default: next_pc = pc_plus4;
    endcase
  end

  // pcsource only matters on the cycle an instruction actually leaves EXEC.
  assign retire     = (state == EXEC) && !stall;
  assign misaligned = (next_pc[1:0] != 2'b00);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  state_nxt = FETCH;
      FETCH: if (imem_ack) state_nxt = EXEC;
      EXEC:  if (!stall) state_nxt = misaligned ? HALT : FETCH;
      HALT:  state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc_q     <= RESET_PC;
      ir_q     <= 32'd0;
      retire_q <= 32'd0;
      fault_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if ((state == FETCH) && imem_ack) ir_q <= imem_rdata;
      if (retire) begin
        retire_q <= retire_q + 32'd1;
        if (misaligned) fault_q <= 1'b1;
        else            pc_q    <= next_pc;
      end
    end
  end

  assign imem_req    = (state == FETCH);
  assign imem_addr   = pc_q;
  assign instr_valid = (state == EXEC);
  assign instr       = ir_q;
  assign op          = ir_q[31:26];
  assign func        = ir_q[5:0];
  assign pc          = pc_q;
  assign retire_cnt  = retire_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: fetch handshake, next-PC modes, stall, reset abort, fault halt.
module tb_instr_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [1:0]  pcsource;
  logic [31:0] rs_data;
  logic        stall;
  logic [31:0] instr;
  logic [5:0]  op;
  logic [5:0]  func;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] retire_cnt;
  logic        fault;

  int errors = 0;
  int checks = 0;
  int exp_retire = 0;
  int valid_cnt = 0;

  instr_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .pcsource(pcsource), .rs_data(rs_data), .stall(stall),
    .instr(instr), .op(op), .func(func), .instr_valid(instr_valid),
    .pc(pc), .pc_plus4(pc_plus4), .retire_cnt(retire_cnt), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_req();
    int n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("fetch_req", 32'(imem_req), 32'd1);
  endtask

  // Present one fetch; returns on the first EXEC cycle.
  task automatic fetch(input logic [31:0] exp_addr, input logic [31:0] rdata, input int delay);
    wait_req();
    check("fetch_addr", imem_addr, exp_addr);
    check("fetch_valid_low", 32'(instr_valid), 32'd0);
    repeat (delay) @(negedge clk);
    check("fetch_req_held", 32'(imem_req), 32'd1);
    check("fetch_addr_held", imem_addr, exp_addr);
    imem_ack   = 1'b1;
    imem_rdata = rdata;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = 32'd0;
    check("exec_valid", 32'(instr_valid), 32'd1);
    check("exec_req_low", 32'(imem_req), 32'd0);
    check("exec_instr", instr, rdata);
  endtask

  task automatic exec_step(input logic [1:0] ps, input logic [31:0] rs, input logic [31:0] exp_pc);
    pcsource = ps;
    rs_data  = rs;
    stall    = 1'b0;
    @(negedge clk);
    exp_retire++;
    check("next_pc", pc, exp_pc);
    check("retire_cnt", retire_cnt, 32'(exp_retire));
    check("valid_after_exec", 32'(instr_valid), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = 32'd0;
    pcsource = 2'b00; rs_data = 32'd0; stall = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_pc", pc, RST_PC);
    check("rst_ir", instr, 32'd0);
    check("rst_retire", retire_cnt, 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    rst_n = 1'b1;

    // First instruction, ack after 3 wait cycles
    fetch(RST_PC, 32'h2008_0005, 3);
    check("op_addi", 32'(op), 32'h08);
    check("func_addi", 32'(func), 32'h05);
    check("pc_exec", pc, RST_PC);
    check("pc_plus4", pc_plus4, 32'h0040_0004);
    exec_step(2'b00, 32'd0, 32'h0040_0004);

    fetch(32'h0040_0004, 32'h0000_0020, 0);
    exec_step(2'b00, 32'd0, 32'h0040_0008);
    fetch(32'h0040_0008, 32'h0000_0020, 0);
    exec_step(2'b00, 32'd0, 32'h0040_000C);
    fetch(32'h0040_000C, 32'h0000_0020, 0);
    exec_step(2'b00, 32'd0, 32'h0040_0010);

    // Backward branch then forward branch from 0x0040_0010
    fetch(32'h0040_0010, 32'h1000_FFFE, 0);
    exec_step(2'b01, 32'd0, 32'h0040_000C);
    fetch(32'h0040_000C, 32'h0000_0020, 0);
    exec_step(2'b00, 32'd0, 32'h0040_0010);
    fetch(32'h0040_0010, 32'h1000_0003, 1);
    exec_step(2'b01, 32'd0, 32'h0040_0020);

    // Stall four cycles with pcsource toggling and a misaligned rs_data
    fetch(32'h0040_0020, 32'h0000_0020, 0);
    valid_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      stall    = 1'b1;
      pcsource = 2'(k);
      rs_data  = 32'h0000_0001;
      if (instr_valid) valid_cnt++;
      @(negedge clk);
      check("stall_pc", pc, 32'h0040_0020);
      check("stall_ir", instr, 32'h0000_0020);
      check("stall_retire", retire_cnt, 32'(exp_retire));
    end
    if (instr_valid) valid_cnt++;
    exec_step(2'b00, 32'd0, 32'h0040_0024);
    check("stall_valid_cycles", 32'(valid_cnt), 32'd5);

    // Register jump
    fetch(32'h0040_0024, 32'h03E0_0008, 0);
    exec_step(2'b10, 32'h0040_0100, 32'h0040_0100);

    // Reset during an outstanding fetch; ack while in reset is ignored
    wait_req();
    check("abort_addr", imem_addr, 32'h0040_0100);
    #2 rst_n = 1'b0;
    #1;
    check("abort_req", 32'(imem_req), 32'd0);
    check("abort_pc", pc, RST_PC);
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk);
    check("abort_ir", instr, 32'd0);
    check("abort_retire", retire_cnt, 32'd0);
    imem_ack   = 1'b0;
    imem_rdata = 32'd0;
    rst_n      = 1'b1;
    exp_retire = 0;

    // jal from reset PC
    fetch(RST_PC, 32'h0C10_0008, 0);
    check("op_jal", 32'(op), 32'h03);
    exec_step(2'b11, 32'd0, 32'h0040_0020);

    // Misaligned jr target halts the core
    fetch(32'h0040_0020, 32'h0000_0008, 0);
    exec_step(2'b10, 32'h0040_0102, 32'h0040_0020);
    check("halt_fault", 32'(fault), 32'd1);
    check("halt_req", 32'(imem_req), 32'd0);
    imem_ack = 1'b1;
    repeat (3) @(negedge clk);
    check("halt_req_held", 32'(imem_req), 32'd0);
    check("halt_valid", 32'(instr_valid), 32'd0);
    check("halt_pc_held", pc, 32'h0040_0020);
    check("halt_fault_held", 32'(fault), 32'd1);
    check("halt_retire_held", retire_cnt, 32'(exp_retire));
    imem_ack = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: observed=no_finish expected=finish");
    $fatal(1, "timeout");
  end

endmodule
